// File: rtl/dense_row_sequencer_pkg.sv
// Shared types and helpers for the dense-layer row sequencer.
// Sign-magnitude constants assume the default 32-bit datapath.
package dense_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WRITE,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam int DATA_W = 32;
    localparam int SIGN_BIT = DATA_W - 1;
    localparam logic [DATA_W-1:0] MAG_MAX =
        {1'b0, {(DATA_W-1){1'b1}}};

    function automatic int row_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dense_row_sequencer_if.sv
// Row store, dot-product engine and output buffer bundle.
// master = sequencer side, slave = datapath/memory side.
interface dense_row_sequencer_if #(
    parameter int N     = 32,
    parameter int ROW_W = 3
);

    logic [ROW_W-1:0] row_addr;
    logic [N-1:0]     bias;
    logic             dot_start;
    logic             dot_done;
    logic [N-1:0]     dot_result;
    logic             y_we;
    logic [ROW_W-1:0] y_addr;
    logic [N-1:0]     y_data;

    modport master (
        output row_addr,
        output dot_start,
        output y_we,
        output y_addr,
        output y_data,
        input  bias,
        input  dot_done,
        input  dot_result
    );

    modport slave (
        input  row_addr,
        input  dot_start,
        input  y_we,
        input  y_addr,
        input  y_data,
        output bias,
        output dot_done,
        output dot_result
    );

endinterface

// File: rtl/dense_row_sequencer_sm_sat_add.sv
// Combinational sign-magnitude adder with magnitude saturation.
// A zero magnitude always carries a positive sign.
module sm_sat_add
    import dense_seq_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    logic         a_s;
    logic         b_s;
    logic [N-2:0] a_m;
    logic [N-2:0] b_m;
    logic [N-1:0] add_m;
    logic         s;
    logic [N-2:0] m;

    assign a_s = a[N-1];
    assign b_s = b[N-1];
    assign a_m = a[N-2:0];
    assign b_m = b[N-2:0];
    assign add_m = {1'b0, a_m} + {1'b0, b_m};

    always_comb begin
        s = 1'b0;
        m = '0;
        if (a_s == b_s) begin
            s = a_s;
            m = add_m[N-1] ? '1 : add_m[N-2:0];
        end else if (a_m >= b_m) begin
            s = a_s;
            m = a_m - b_m;
        end else begin
            s = b_s;
            m = b_m - a_m;
        end
        if (m == '0)
            s = 1'b0;
    end

    assign sum = {s, m};

endmodule

// File: rtl/dense_row_sequencer.sv
// Time-shares one dot-product engine across the M rows of a dense layer.
// RELU_EN: when defined, negative results are written as zero.
module dense_row_sequencer
    import dense_seq_pkg::*;
#(
    parameter int Q       = 15,
    parameter int N       = 32,
    parameter int H       = 10,
    parameter int M       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    dense_row_sequencer_if.master bus
);

    localparam int ROW_W = row_w(M);
    localparam int CW    = $clog2(TIMEOUT) + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);
    localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT - 1);

    if (Q >= N || H < 1 || M < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("dense_row_sequencer: bad parameters");
    end

    state_t        state;
    logic [CW-1:0] tcnt;
    logic [N-1:0]  sum;
    logic [N-1:0]  act;

    sm_sat_add #(.N(N)) u_add (
        .a   (bus.dot_result),
        .b   (bus.bias),
        .sum (sum)
    );

`ifdef RELU_EN
    assign act = sum[N-1] ? '0 : sum;
`else
    assign act = sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            tcnt          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bus.dot_start <= 1'b0;
            bus.y_we      <= 1'b0;
            bus.row_addr  <= '0;
            bus.y_addr    <= '0;
            bus.y_data    <= '0;
        end else begin
            done     <= 1'b0;
            bus.y_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_FETCH;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        bus.row_addr <= '0;
                    end
                end
                S_FETCH: begin
                    state         <= S_LAUNCH;
                    bus.dot_start <= 1'b1;
                    tcnt          <= '0;
                end
                S_LAUNCH: begin
                    if (bus.dot_done) begin
                        state         <= S_WRITE;
                        bus.dot_start <= 1'b0;
                        bus.y_we      <= 1'b1;
                        bus.y_addr    <= bus.row_addr;
                        bus.y_data    <= act;
                    end else if (tcnt == TO_LAST) begin
                        // abort the layer; rows already written stay valid
                        state         <= S_FINISH;
                        bus.dot_start <= 1'b0;
                        error         <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // engine must drop done before the next launch
                    if (!bus.dot_done) begin
                        if (bus.row_addr == LAST_ROW) begin
                            state <= S_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_FETCH;
                            bus.row_addr <= bus.row_addr + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dense_row_sequencer.md
# dense_row_sequencer

Control block that evaluates one fully-connected layer, y[r] = act(w[r]·x + b[r]) for r = 0..M-1, by time-sharing a single `dotproduct` engine across all M output neurons. Each row it addresses the external weight/bias store, runs the shared engine, adds the bias with saturation, applies the optional activation and writes y[r] to the layer output buffer. It sits between the layer-level inference controller (start/done) and the dot-product datapath.

## Interface
- Q, 15, fractional bits of the sign-magnitude fixed-point format (MSB = sign).
- N, 32, data width.
- H, 10, vector length; passed through only, no logic depends on it.
- M, 8, number of rows (neurons), M ≥ 1.
- TIMEOUT, 64, maximum cycles in LAUNCH before abort.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  layer start pulse; ignored unless IDLE.
- busy  out  1  high from the cycle after start is accepted until FINISH.
- done  out  1  one-cycle pulse at end of layer, normal or aborted.
- error  out  1  sticky timeout flag; cleared on next accepted start.
- row_addr  out  $clog2(M) (min 1)  weight/bias row index.
- bias  in  N  b[row_addr]; valid one cycle after row_addr changes (registered read).
- dot_start  out  1  level start to the engine.
- dot_done  in  1  engine completion level.
- dot_result  in  N  engine result, valid while dot_done = 1.
- y_we  out  1  output buffer write strobe.
- y_addr  out  $clog2(M) (min 1)  output buffer address.
- y_data  out  N  activated result.

## Operation
- States: IDLE, FETCH, LAUNCH, WRITE, DRAIN, FINISH.
- IDLE: start=1 → FETCH, row=0, error cleared.
- FETCH (1 cycle): row_addr=row; store read in flight → LAUNCH.
- LAUNCH: dot_start=1. dot_done=1 sampled → register y_data = act(sat_add(dot_result, bias)), y_addr=row → WRITE. Timeout counter reaching TIMEOUT-1 without dot_done → error=1 → FINISH.
- WRITE (1 cycle): y_we=1 → DRAIN.
- DRAIN: dot_start=0; wait for dot_done=0 (engine re-armed). Then row==M-1 → FINISH, else row+1 → FETCH.
- FINISH (1 cycle): done=1, busy=0 → IDLE.
- Bias add: sign-magnitude. Same signs: add magnitudes, saturate to 2^(N-1)-1 on carry. Opposite signs: subtract smaller from larger magnitude, take sign of larger. Result -0 normalised to +0.
- row_addr holds its value outside FETCH; y_addr/y_data hold until next capture.

## Timing
- Reset (rst_n=0 at posedge): state IDLE; busy, done, error, dot_start, y_we = 0; row_addr, y_addr, y_data = 0. Reset mid-layer aborts immediately, no write, no done.
- start at edge t: FETCH at t+1 (busy=1), LAUNCH t+2, dot_start=1 from t+2.
- Per row: 1 FETCH + L LAUNCH (L = cycles until dot_done) + 1 WRITE + ≥1 DRAIN. With engine dot_done rising 1 cycle after dot_start and falling 1 cycle after its drop, a row takes 4 cycles; layer = 4M + 1 cycles from start to done.
- start while busy: ignored, no effect on state or error.
- dot_done already high on LAUNCH entry: captured in first LAUNCH cycle (caller's responsibility; DRAIN prevents this for own launches).
- Timeout abort: no write for the failing row; rows already written remain valid.

## Configuration
- RELU_EN defined: act(v) = 0 when sign bit = 1, else v.
- RELU_EN undefined: act(v) = v (identity, negative values written as is).

## Structure
- Package dense_seq_pkg: state enum type, ROW_W = max(1,$clog2(M)) helper function, sign-magnitude constants (SIGN_BIT, MAG_MAX).
- One sub-module: sm_sat_add (combinational N-bit sign-magnitude saturating adder), instantiated once.
- Engine, weight store and output buffer are external.

## Test plan
- M=4, engine model done 1 cycle after dot_start, dot_result=0x00008000 (1.0), bias=0x00004000 (0.5) → four writes of 0x0000C000 at addr 0..3, done 17 cycles after start, error=0.
- dot_result=0x80010000 (-2.0), bias=0x00008000 → y_data=0x80008000 (-1.0) without RELU_EN; 0x00000000 with RELU_EN.
- dot_result=0x7FFFFFFF, bias=0x00000001 → y_data=0x7FFFFFFF (saturated); dot_result=0x80008000, bias=0x00008000 → 0x00000000.
- Engine never asserts dot_done, TIMEOUT=64 → done pulse 66 cycles after start, error=1, y_we never high; next start clears error.
- Engine done latency 5 cycles, start re-pulsed mid-layer → ignored, row order 0..M-1 unchanged.
- rst_n low during LAUNCH of row 2 → next cycle all outputs at reset values, no done; fresh start runs full layer from row 0.
